// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB master port between NREQ requesters
//
// Purpose: grants one requester at a time onto an APB bus. Each transfer is
// SETUP then ACCESS. The slave select is decoded from PADDR[AW-1]. All
// outputs are registered.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to end a stalled ACCESS phase
// with ERR=1 after 15 waited cycles.
//
// Ports:
//   CLK, RST_N              clock, synchronous active-low reset
//   REQ, REQ_WRITE          per-requester request and direction (1 = write)
//   REQ_ADDR, REQ_WDATA     per-requester address/data, slice i at [i*W +: W]
//   GNT, DONE               one-hot single-cycle grant / completion pulses
//   RDATA, ERR              last read data; error of the completing transfer
//   PSEL1, PSEL2, PENABLE,
//   PWRITE, PADDR, PWDATA   APB master request side
//   PRDATA, PREADY, PSLVERR APB slave response side
module apb_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 9,
    parameter int DW   = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    REQ_WRITE,
    input  logic [NREQ*AW-1:0] REQ_ADDR,
    input  logic [NREQ*DW-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    DONE,
    output logic [DW-1:0]      RDATA,
    output logic               ERR,
    output logic               PSEL1,
    output logic               PSEL2,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [AW-1:0]      PADDR,
    output logic [DW-1:0]      PWDATA,
    input  logic [DW-1:0]      PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    state_t          state;
    logic [LW-1:0]   last_grant;
    logic [LW-1:0]   owner;

    logic [LW-1:0]   win;
    logic            found;
    int              idx;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            win_write;
    logic [NREQ-1:0] win_onehot;
    logic [NREQ-1:0] owner_onehot;
    logic            complete;
    logic            xfer_err;
    logic            start;

`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0]      wait_cnt;
    logic [3:0]      wait_nxt;
    logic            timeout;

    // The stalled cycle that would bring the count to 15 is the last one
    // waited; its closing edge completes the transfer.
    assign wait_nxt = wait_cnt + 4'd1;
    assign timeout  = !PREADY && (wait_nxt == 4'd15);
    assign complete = PREADY || timeout;
    assign xfer_err = PREADY ? PSLVERR : 1'b1;
`else
    assign complete = PREADY;
    assign xfer_err = PSLVERR;
`endif

    // Round-robin search starting just above the last granted index.
    always_comb begin
        win   = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx[LW-1:0];
            end
        end
    end

    always_comb begin
        win_onehot        = '0;
        win_onehot[win]   = 1'b1;
        owner_onehot      = '0;
        owner_onehot[owner] = 1'b1;
        win_addr  = REQ_ADDR[int'(win)*AW +: AW];
        win_wdata = REQ_WDATA[int'(win)*DW +: DW];
        win_write = REQ_WRITE[win];
    end

    // Arbitration only happens from IDLE or on the completing ACCESS edge,
    // so REQ changes during SETUP or a stalled ACCESS are never observed.
    assign start = found && ((state == S_IDLE) || ((state == S_ACCESS) && complete));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            last_grant <= LW'(NREQ - 1);
            owner      <= '0;
            GNT        <= '0;
            DONE       <= '0;
            RDATA      <= '0;
            ERR        <= 1'b0;
            PSEL1      <= 1'b0;
            PSEL2      <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt   <= 4'd0;
`endif
        end else begin
            GNT  <= '0;
            DONE <= '0;
            case (state)
                S_IDLE: begin
                    state <= S_IDLE;
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (complete) begin
                        DONE <= owner_onehot;
                        ERR  <= xfer_err;
                        if (PREADY && !PWRITE) begin
                            RDATA <= PRDATA;
                        end
                        state   <= S_IDLE;
                        PSEL1   <= 1'b0;
                        PSEL2   <= 1'b0;
                        PENABLE <= 1'b0;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_nxt;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // A new grant overrides the return to IDLE, giving back-to-back SETUP.
            if (start) begin
                state      <= S_SETUP;
                owner      <= win;
                last_grant <= win;
                GNT        <= win_onehot;
                PADDR      <= win_addr;
                PWDATA     <= win_wdata;
                PWRITE     <= win_write;
                PSEL1      <= ~win_addr[AW-1];
                PSEL2      <= win_addr[AW-1];
                PENABLE    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                wait_cnt   <= 4'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - self-checking bench for apb_rr_arbiter (directed cases plus random traffic)
module tb_apb_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 9;
    localparam int DW   = 8;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err;
    logic               psel1, psel2, penable, pwrite;
    logic [AW-1:0]      paddr;
    logic [DW-1:0]      pwdata;
    logic [DW-1:0]      prdata;
    logic               pready, pslverr;

    int checks = 0;
    int failures = 0;

    apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ(req), .REQ_WRITE(req_write), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .GNT(gnt), .DONE(done), .RDATA(rdata), .ERR(err),
        .PSEL1(psel1), .PSEL2(psel2), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks which bus phase a transfer is in and the
    // rotating priority pointer, and predicts the outputs of the next cycle.
    bit              m_valid = 0;
    int              m_phase;   // 0 bus free, 1 address phase, 2 data phase
    int              m_last;
    int              m_owner;
    logic [NREQ-1:0] e_gnt, e_done;
    logic [DW-1:0]   e_rdata, e_pwdata;
    logic [AW-1:0]   e_paddr;
    logic            e_err, e_psel1, e_psel2, e_pen, e_pwrite;

    task automatic model_grant();
        int w;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (w < 0 && req[j]) w = j;
        end
        m_last   = w;
        m_owner  = w;
        e_gnt    = '0;
        e_gnt[w] = 1'b1;
        e_paddr  = req_addr[w*AW +: AW];
        e_pwdata = req_wdata[w*DW +: DW];
        e_pwrite = req_write[w];
        e_psel2  = e_paddr[AW-1];
        e_psel1  = !e_paddr[AW-1];
        e_pen    = 1'b0;
        m_phase  = 1;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_valid = 1;
            m_phase = 0; m_last = NREQ - 1; m_owner = 0;
            e_gnt = '0; e_done = '0; e_rdata = '0; e_err = 0;
            e_psel1 = 0; e_psel2 = 0; e_pen = 0; e_pwrite = 0;
            e_paddr = '0; e_pwdata = '0;
            return;
        end
        if (!m_valid) return;
        e_gnt  = '0;
        e_done = '0;
        if (m_phase == 0) begin
            if (req != 0) model_grant();
        end else if (m_phase == 1) begin
            e_pen   = 1'b1;
            m_phase = 2;
        end else if (pready) begin
            e_done[m_owner] = 1'b1;
            e_err = pslverr;
            if (!e_pwrite) e_rdata = prdata;
            if (req != 0) model_grant();
            else begin
                m_phase = 0; e_psel1 = 0; e_psel2 = 0; e_pen = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("m_gnt", gnt, e_gnt);
            chk("m_done", done, e_done);
            chk("m_psel1", psel1, e_psel1);
            chk("m_psel2", psel2, e_psel2);
            chk("m_penable", penable, e_pen);
            chk("m_rdata", rdata, e_rdata);
            if (e_done != 0) chk("m_err", err, e_err);
            if (e_psel1 || e_psel2) begin
                chk("m_paddr", paddr, e_paddr);
                chk("m_pwrite", pwrite, e_pwrite);
                chk("m_pwdata", pwdata, e_pwdata);
            end
        end
    end

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_done(output logic [NREQ-1:0] seen);
        seen = '0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            seen = done;
        end
    endtask

    int              acc;
    int              g_idx[5];
    int              g_cyc[5];
    int              ng;
    int              ndone;
    logic [NREQ-1:0] dseen;

    initial begin
        rst_n = 0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        prdata = '0; pready = 1; pslverr = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_psel", {psel1, psel2, penable, pwrite}, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        rst_n = 1;

        // single write to slave 1
        set_req(0, 1'b1, 9'h005, 8'hA5);
        @(negedge clk);
        chk("wr_gnt", gnt, 4'b0001);
        chk("wr_psel1", {psel1, psel2, penable}, 3'b100);
        req = '0;
        @(negedge clk);
        chk("wr_penable", penable, 1);
        chk("wr_pwdata", pwdata, 8'hA5);
        @(negedge clk);
        chk("wr_done", done, 4'b0001);
        chk("wr_err", err, 0);

        // read from slave 2 with three wait states
        set_req(2, 1'b0, 9'h1F0, 8'h00);
        pready = 0;
        @(negedge clk);
        chk("rd_gnt", gnt, 4'b0100);
        chk("rd_psel2", {psel1, psel2}, 2'b01);
        req = '0;
        acc = 0; dseen = '0;
        for (int c = 0; c < 20 && dseen == 0; c++) begin
            @(negedge clk);
            dseen = done;
            if (done == 0 && penable) begin
                acc++;
                pready = (acc == 4);
                prdata = 8'h3C;
            end
        end
        chk("rd_access_cycles", acc, 4);
        chk("rd_done", dseen, 4'b0100);
        chk("rd_rdata", rdata, 8'h3C);
        pready = 1;

        // reset during ACCESS, then requester 3 wins from the reset pointer
        set_req(0, 1'b1, 9'h010, 8'h11);
        pready = 0;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("ra_in_access", penable, 1);
        rst_n = 0;
        @(negedge clk);
        chk("ra_done", done, 0);
        chk("ra_outputs", {gnt, psel1, psel2, penable, pwrite, paddr, pwdata}, 0);
        rst_n = 1;
        pready = 1;
        set_req(3, 1'b1, 9'h020, 8'h33);
        @(negedge clk);
        chk("ra_gnt3", gnt, 4'b1000);
        chk("ra_no_done", done, 0);
        req = '0;
        wait_done(dseen);
        chk("ra_done3", dseen, 4'b1000);

        // contention: all four held high
        for (int i = 0; i < NREQ; i++) set_req(i, i[0], 9'(i * 64 + 3), 8'(i + 8'h50));
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (gnt != 0) begin
                g_idx[ng] = $clog2(gnt);
                g_cyc[ng] = c;
                ng++;
            end
        end
        req = '0;
        chk("ct_count", ng, 5);
        for (int k = 0; k < 5; k++) chk("ct_order", (k < ng) ? g_idx[k] : -1, k % NREQ);
        for (int k = 1; k < 5; k++) chk("ct_gap", (k < ng) ? g_cyc[k] - g_cyc[k-1] : -1, 2);
        wait_done(dseen);

        // slave error followed by a clean transfer
        set_req(1, 1'b1, 9'h044, 8'h77);
        pslverr = 1;
        @(negedge clk);
        req = '0;
        wait_done(dseen);
        chk("se_done", dseen, 4'b0010);
        chk("se_err", err, 1);
        pslverr = 0;
        set_req(2, 1'b0, 9'h0C4, 8'h00);
        @(negedge clk);
        req = '0;
        wait_done(dseen);
        chk("se_next_done", dseen, 4'b0100);
        chk("se_next_err", err, 0);

        // random traffic against the model
        ndone = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done != 0) ndone++;
            rst_n = ($urandom_range(999) >= 3);
            pready = ($urandom_range(99) < 60);
            pslverr = ($urandom_range(99) < 20);
            prdata = 8'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && gnt[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(99) < 30)
                        set_req(i, 1'($urandom), 9'($urandom), 8'($urandom));
                end else if (req[i]) begin
                    if ($urandom_range(99) < 3) req[i] = 1'b0;
                end else if ($urandom_range(99) < 25) begin
                    set_req(i, 1'($urandom), 9'($urandom), 8'($urandom));
                end
            end
        end
        chk("rnd_progress", (ndone > 100) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_rr_arbiter.md
APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters (2..8); AW, 9, APB address width; DW, 8, APB data width.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 REQ  input  NREQ  per-requester transfer request; held high until the matching GNT bit is seen.
REQ-005 REQ_WRITE  input  NREQ  per-requester direction: 1 is write, 0 is read.
REQ-006 REQ_ADDR  input  NREQ*AW  per-requester address; slice i is bits [i*AW +: AW].
REQ-007 REQ_WDATA  input  NREQ*DW  per-requester write data; slice i is bits [i*DW +: DW].
REQ-008 GNT  output  NREQ  one-hot, one-cycle grant pulse.
REQ-009 DONE  output  NREQ  one-hot, one-cycle completion pulse.
REQ-010 RDATA  output  DW  read data of the last completed read.
REQ-011 ERR  output  1  error status of the completing transfer; valid while any DONE bit is high.
REQ-012 PSEL1 and PSEL2  output  1 each  slave selects.
REQ-013 PENABLE, PWRITE  output  1 each  APB enable and direction.
REQ-014 PADDR  output  AW  APB address.
REQ-015 PWDATA  output  DW  APB write data.
REQ-016 PRDATA  input  DW  slave read data.
REQ-017 PREADY, PSLVERR  input  1 each  slave ready and slave error.

Function
REQ-018 FSM states SHALL be IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-019 Arbitration SHALL occur in IDLE, and in ACCESS on the cycle PREADY=1; no other state arbitrates.
REQ-020 The winner SHALL be the first REQ bit found at or above index (last_grant+1) mod NREQ, searching upward with wrap-around.
REQ-021 At the arbitration edge, the block SHALL latch the winner's REQ_ADDR, REQ_WDATA and REQ_WRITE, update last_grant, and move to SETUP.
REQ-022 In SETUP: GNT[winner]=1, PENABLE=0, and PADDR/PWRITE/PWDATA carry the latched values; the next state is always ACCESS.
REQ-023 Slave select in SETUP and ACCESS SHALL decode PADDR[AW-1]: value 0 selects PSEL1=1, PSEL2=0; value 1 selects PSEL1=0, PSEL2=1.
REQ-024 In ACCESS: PENABLE=1; PADDR, PWRITE, PWDATA and PSELx held stable; the block waits while PREADY=0.
REQ-025 When PREADY=1 in ACCESS, on the next cycle:
- DONE[owner]=1 for one cycle;
- ERR=PSLVERR;
- RDATA=PRDATA if PWRITE=0, otherwise RDATA holds.
REQ-026 After completion, the next state SHALL be SETUP if any REQ is high (back-to-back transfer), otherwise IDLE with all PSELx=0 and PENABLE=0.
REQ-027 Minimum transfer SHALL be 2 cycles (SETUP, then ACCESS with PREADY=1); a requester SHALL never be granted twice while another REQ is pending.
REQ-028 If REQ drops before GNT, no transfer SHALL start for that requester; REQ levels during SETUP and mid-ACCESS SHALL be ignored.

Reset
REQ-029 RST_N=0 at a clock edge SHALL set the state to IDLE and last_grant=NREQ-1 (requester 0 has first priority).
REQ-030 Reset SHALL clear GNT, DONE, RDATA, ERR, PSEL1, PSEL2, PENABLE, PWRITE, PADDR and PWDATA to 0.
REQ-031 Reset mid-transfer SHALL abort the transfer silently: no DONE pulse, and bus idle on the next cycle.

Configuration
REQ-032 With macro APB_ARB_TIMEOUT_EN defined, a 4-bit counter SHALL count ACCESS cycles while PREADY=0.
REQ-033 When that counter reaches 15, the block SHALL complete the transfer as if PREADY=1 and PSLVERR=1: DONE pulses, ERR=1, RDATA unchanged.
REQ-034 With APB_ARB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely for PREADY and no counter SHALL exist.

Verification
REQ-035 Single write: REQ=0001, addr 0x005, data 0xA5, PREADY=1 -> GNT=0001 and PSEL1 in SETUP; PENABLE=1 with PWDATA=0xA5; DONE=0001 two cycles after GNT, ERR=0.
REQ-036 Read with wait states: REQ=0100, addr 0x1F0, PREADY low 3 cycles then high with PRDATA=0x3C -> PSEL2=1; ACCESS lasts 4 cycles; DONE=0100, RDATA=0x3C.
REQ-037 Contention: REQ=1111 held, re-raised after each GNT -> grant order 0,1,2,3,0 with back-to-back SETUP and no IDLE gap.
REQ-038 Slave error: PSLVERR=1 with PREADY=1 -> DONE pulse with ERR=1; the next transfer completes with ERR=0.
REQ-039 Reset in ACCESS: RST_N=0 for 1 cycle with PREADY=0 -> no DONE; all outputs 0; the next REQ=1000 is granted without waiting on the stale pointer.
REQ-040 With APB_ARB_TIMEOUT_EN defined and PREADY stuck 0 -> DONE with ERR=1 after 15 waited ACCESS cycles; the FSM returns to IDLE.
